// File: rtl/life_pkg.sv
// Shared constants, state encoding and neighbour-count helper for the
// Game-of-Life generation engine.
package life_pkg;

    localparam int GRID_N = 32;
    localparam int GRID_M = 24;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } evo_state_t;

    // Eight one-bit neighbours summed into 4 bits so a full count of 8 cannot overflow.
    function automatic logic [3:0] count_nbrs(input logic [7:0] nbr);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int k = 0; k < 8; k++) begin
            cnt = cnt + {3'b000, nbr[k]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/life_cell_rule.sv
// B3/S23 update for a single cell given its current state and eight neighbours.
module life_cell_rule
    import life_pkg::*;
(
    input  logic       alive,
    input  logic [7:0] nbr,
    output logic       alive_next
);

    logic [3:0] cnt_s;

    // Birth on exactly three neighbours, survival on two or three.
    always_comb begin
        cnt_s      = count_nbrs(nbr);
        alive_next = (cnt_s == 4'd3) | (alive & (cnt_s == 4'd2));
    end

endmodule

// File: rtl/life_evo_seq.sv
// Sequential Game-of-Life engine: snapshots the board on start, then writes
// one row of the next generation per clock and pulses done after the last row.
module life_evo_seq
    import life_pkg::*;
#(
    parameter int P_PARAM_N = GRID_N,
    parameter int P_PARAM_M = GRID_M
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [P_PARAM_N*P_PARAM_M-1:0] prev,
    output logic [P_PARAM_N*P_PARAM_M-1:0] next,
    output logic                           busy,
    output logic                           done
);

    localparam int N     = P_PARAM_N;
    localparam int M     = P_PARAM_M;
    localparam int B     = N * M;
    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(M - 1);

    evo_state_t       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [B-1:0]     snap_q, snap_d;
    logic [B-1:0]     next_q, next_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Padded rows: bit 0 and bit N+1 are the dead columns outside the board.
    logic [N+1:0]     up_s, mid_s, dn_s;
    logic [N-1:0]     row_new_s;

    // Select snapshot rows r-1, r, r+1 around the active row, dead outside the board.
    always_comb begin
        up_s  = '0;
        mid_s = '0;
        dn_s  = '0;
        mid_s[N:1] = snap_q[int'(row_q)*N +: N];
        if (row_q != '0) begin
            up_s[N:1] = snap_q[(int'(row_q) - 1)*N +: N];
        end else begin
            up_s[N:1] = '0;
        end
        if (row_q != LAST_ROW) begin
            dn_s[N:1] = snap_q[(int'(row_q) + 1)*N +: N];
        end else begin
            dn_s[N:1] = '0;
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_cell
        life_cell_rule u_rule (
            .alive      (mid_s[j+1]),
            .nbr        ({up_s[j], up_s[j+1], up_s[j+2],
                          mid_s[j],            mid_s[j+2],
                          dn_s[j], dn_s[j+1], dn_s[j+2]}),
            .alive_next (row_new_s[j])
        );
    end

    // Next-state logic: accept start only in IDLE, write one row per CALC cycle.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        snap_d  = snap_q;
        next_d  = next_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    snap_d  = prev;
                    row_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            CALC: begin
                next_d[int'(row_q)*N +: N] = row_new_s;
                // Explicit compare against the last row so a non-power-of-two M never wraps.
                if (row_q == LAST_ROW) begin
                    state_d = IDLE;
                    row_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset clears any partial generation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            snap_q  <= '0;
            next_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            snap_q  <= snap_d;
            next_q  <= next_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign next = next_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
